// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers
// for the sequential ALU with multiply/divide.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_t;

  function automatic logic is_iterative(
    input logic [3:0] op
  );
    return op inside {ALU_MUL, ALU_MULHU,
                      ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier and
// restoring divider, one step per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mul,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   mcand, dvsr;
  logic [WIDTH-1:0]   q, r, q_n, r_n;
  logic [WIDTH:0]     psum, trial;
  logic [CW-1:0]      cnt;
  logic               mul_q;

  always_comb begin
    psum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, mcand} : '0);
    acc_n = {psum, acc[WIDTH-1:1]};
    trial = {r, q[WIDTH-1]} - {1'b0, dvsr};
    // Negative trial: restore by keeping the shift.
    if (trial[WIDTH]) begin
      r_n = {r[WIDTH-2:0], q[WIDTH-1]};
      q_n = {q[WIDTH-2:0], 1'b0};
    end else begin
      r_n = trial[WIDTH-1:0];
      q_n = {q[WIDTH-2:0], 1'b1};
    end
  end

  // Outputs show the value after the step in flight.
  assign prod_hi = acc_n[2*WIDTH-1:WIDTH];
  assign prod_lo = acc_n[WIDTH-1:0];
  assign quot    = q_n;
  assign rem     = r_n;
  assign last    = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      dvsr  <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      mul_q <= 1'b0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      dvsr  <= b;
      q     <= a;
      r     <= '0;
      cnt   <= '0;
      mul_q <= mul;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (mul_q) begin
        acc <= acc_n;
      end else begin
        q <= q_n;
        r <= r_n;
      end
    end
  end

endmodule

// File: rtl/alu_seq_mdu.sv
// Execute-stage ALU: registered simple ops,
// iterative mul/div behind Start/Ready/Done.
module alu_seq_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             signflag,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t state, state_n;

  logic             accept, iter_go, last;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] prod_hi, prod_lo;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] simple_res, iter_res;
  logic             simple_c, simple_v;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SW-1:0]    shamt;

  assign accept  = Start && Ready;
  assign iter_go = accept && MDU_EN
                && is_iterative(ALUControl);

  always_comb begin
    state_n = state;
    Ready   = 1'b1;
    Done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_n = iter_go ? ST_CALC : ST_FIN;
      end
      ST_CALC: begin
        Ready = 1'b0;
        if (last) state_n = ST_FIN;
      end
      ST_FIN: begin
        Done = 1'b1;
        if (!accept)
          state_n = ST_IDLE;
        else
          state_n = iter_go ? ST_CALC : ST_FIN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign shamt = SrcB[SW-1:0];
  assign add_w = {1'b0, SrcA} + {1'b0, SrcB};
  // Carry out of A + ~B + 1 means no borrow.
  assign sub_w = {1'b0, SrcA} + {1'b0, ~SrcB}
               + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    simple_res = '0;
    simple_c   = 1'b0;
    simple_v   = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        simple_res = add_w[M:0];
        simple_c   = add_w[WIDTH];
        simple_v   = (SrcA[M] == SrcB[M])
                  && (add_w[M] != SrcA[M]);
      end
      ALU_SUB: begin
        simple_res = sub_w[M:0];
        simple_c   = sub_w[WIDTH];
        simple_v   = (SrcA[M] != SrcB[M])
                  && (sub_w[M] != SrcA[M]);
      end
      ALU_SLL: simple_res = SrcA << shamt;
      ALU_SRL: simple_res = SrcA >> shamt;
      ALU_SRA:
        simple_res = $signed(SrcA) >>> shamt;
      ALU_SLT:
        simple_res[0] = $signed(SrcA)
                      < $signed(SrcB);
      ALU_SLTU: simple_res[0] = SrcA < SrcB;
      ALU_XOR:  simple_res = SrcA ^ SrcB;
      ALU_OR:   simple_res = SrcA | SrcB;
      ALU_AND:  simple_res = SrcA & SrcB;
      default:  simple_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      ALU_MUL:   iter_res = prod_lo;
      ALU_MULHU: iter_res = prod_hi;
      ALU_DIVU:  iter_res = quot;
      default:   iter_res = rem;
    endcase
  end

  if (MDU_EN) begin : g_mdu
    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .reset   (reset),
      .load    (iter_go),
      .mul     (ALUControl == ALU_MUL ||
                ALUControl == ALU_MULHU),
      .step    (state == ST_CALC),
      .a       (SrcA),
      .b       (SrcB),
      .last    (last),
      .prod_hi (prod_hi),
      .prod_lo (prod_lo),
      .quot    (quot),
      .rem     (rem)
    );
  end else begin : g_no_mdu
    assign last    = 1'b0;
    assign prod_hi = '0;
    assign prod_lo = '0;
    assign quot    = '0;
    assign rem     = '0;
  end

  assign Zero     = (ALUResult == '0);
  assign signflag = ALUResult[M];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= ALU_ADD;
      ALUResult <= '0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state <= state_n;
      if (iter_go) op_q <= ALUControl;
      if (accept && !iter_go) begin
        ALUResult <= simple_res;
        Carry     <= simple_c;
        Overflow  <= simple_v;
      end else if (state == ST_CALC && last) begin
        ALUResult <= iter_res;
        Carry     <= 1'b0;
        Overflow  <= 1'b0;
      end
    end
  end

endmodule
